// File: rtl/branch_fwd_hazard_ctrl.sv
// rtl/branch_fwd_hazard_ctrl.sv - ID-stage branch forwarding, stall and flush control
// Tracks in-flight destination tags (EX/MEM/WB) and drives branch comparator selects.
module branch_fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_is_branch,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  branchtaken,
  output logic [1:0]            forwardAD,
  output logic [1:0]            forwardBD,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  pc_src_branch,
  output logic                  flush_ifid,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      taken_cnt
);

  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] dst;
    logic                  rw;
    logic                  mr;
  } tag_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  tag_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, taken_cnt_q, taken_cnt_d;
  logic haz_rs, haz_rt, stall, taken;

  // Register 0 is hardwired, so it never matches a producer.
  function automatic logic match(input tag_t s, input logic [REG_ADDR_W-1:0] r);
    return s.v & s.rw & (s.dst == r) & (r != '0);
  endfunction

  function automatic logic [1:0] fwd_sel(input tag_t mem_s, input tag_t wb_s,
                                         input logic en, input logic [REG_ADDR_W-1:0] r);
    logic [1:0] sel;
    sel = 2'b00;
    if (en) begin
      if (match(mem_s, r))     sel = mem_s.mr ? 2'b10 : 2'b01;
      else if (match(wb_s, r)) sel = 2'b11;
    end
    return sel;
  endfunction

  always_comb begin
    // EX results are not ready for an ID-stage compare; loads are not ready for anyone.
    haz_rs = id_valid & id_uses_rs & match(ex_q, id_rs) & (id_is_branch | ex_q.mr);
    haz_rt = id_valid & id_uses_rt & match(ex_q, id_rt) & (id_is_branch | ex_q.mr);
    stall  = haz_rs | haz_rt;
    taken  = rst & id_valid & id_is_branch & ~stall & branchtaken;

    forwardAD     = fwd_sel(mem_q, wb_q, id_is_branch & id_uses_rs, id_rs);
    forwardBD     = fwd_sel(mem_q, wb_q, id_is_branch & id_uses_rt, id_rt);
    stall_if      = stall;
    stall_id      = stall;
    pc_src_branch = taken;
    flush_ifid    = taken;
    stall_cnt     = stall_cnt_q;
    taken_cnt     = taken_cnt_q;
  end

  always_comb begin
    ex_d  = '0;
    mem_d = ex_q;
    wb_d  = mem_q;
    if (!stall) begin
      ex_d.v   = id_valid;
      ex_d.dst = id_dst;
      ex_d.rw  = id_regwrite;
      ex_d.mr  = id_memread;
    end

    stall_cnt_d = stall_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (taken && (taken_cnt_q != '1)) taken_cnt_d = taken_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      taken_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_fwd_hazard_ctrl.sv
// tb/tb_branch_fwd_hazard_ctrl.sv - scoreboard bench for branch_fwd_hazard_ctrl
// Expected outputs come from a history-of-issued-slots model of the hazard rules.
module tb_branch_fwd_hazard_ctrl;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_is_branch, id_uses_rs, id_uses_rt;
  logic [4:0] id_rs, id_rt, id_dst;
  logic id_regwrite, id_memread, branchtaken;
  logic [1:0] forwardAD, forwardBD;
  logic stall_if, stall_id, pc_src_branch, flush_ifid;
  logic [CW-1:0] stall_cnt, taken_cnt;

  always #5 clk = ~clk;

  branch_fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_is_branch(id_is_branch),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .branchtaken(branchtaken),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .stall_if(stall_if), .stall_id(stall_id),
    .pc_src_branch(pc_src_branch), .flush_ifid(flush_ifid),
    .stall_cnt(stall_cnt), .taken_cnt(taken_cnt)
  );

  typedef struct {
    bit valid, br, urs, urt;
    bit [4:0] rs, rt, dst;
    bit rw, mr, bt;
  } instr_t;

  typedef struct {
    bit v;
    bit [4:0] dst;
    bit rw, mr;
  } slot_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic sif, sid, pc, fl;
    logic [CW-1:0] sc, tc;
  } exp_t;

  slot_t pipe[$];
  int    stall_n, taken_n;
  exp_t  sbq[$];
  int    tests, failed;
  bit    last_sid;

  function automatic slot_t stage(int k);
    slot_t e;
    e = '{v: 0, dst: 0, rw: 0, mr: 0};
    if (k < pipe.size()) return pipe[k];
    return e;
  endfunction

  function automatic bit writes(slot_t s, bit [4:0] r);
    return s.v && s.rw && s.dst == r && r != 0;
  endfunction

  function automatic bit [1:0] fsel(bit en, bit [4:0] r);
    if (!en) return 2'd0;
    if (writes(stage(1), r)) return stage(1).mr ? 2'd2 : 2'd1;
    if (writes(stage(2), r)) return 2'd3;
    return 2'd0;
  endfunction

  function automatic bit op_stall(bit valid, bit br, bit use_op, bit [4:0] r);
    slot_t ex;
    ex = stage(0);
    return valid && use_op && writes(ex, r) && (br || ex.mr);
  endfunction

  function automatic exp_t expect_of(instr_t i);
    exp_t e;
    bit s;
    e = '0;
    if (rst) begin
      s = op_stall(i.valid, i.br, i.urs, i.rs) || op_stall(i.valid, i.br, i.urt, i.rt);
      e.fa  = fsel(i.br && i.urs, i.rs);
      e.fb  = fsel(i.br && i.urt, i.rt);
      e.sif = s;
      e.sid = s;
      e.pc  = i.valid && i.br && !s && i.bt;
      e.fl  = e.pc;
      e.sc  = CW'(stall_n);
      e.tc  = CW'(taken_n);
    end
    return e;
  endfunction

  task automatic model_edge(instr_t i, bit stalled, bit taken);
    slot_t n;
    if (!rst) begin
      pipe.delete();
      stall_n = 0;
      taken_n = 0;
    end else begin
      n = '{v: 0, dst: 0, rw: 0, mr: 0};
      if (!stalled) n = '{v: i.valid, dst: i.dst, rw: i.rw, mr: i.mr};
      pipe.push_front(n);
      if (pipe.size() > 3) void'(pipe.pop_back());
      if (stalled && stall_n < (1 << CW) - 1) stall_n++;
      if (taken && taken_n < (1 << CW) - 1) taken_n++;
    end
  endtask

  task automatic apply(instr_t i);
    id_valid = i.valid; id_is_branch = i.br; id_uses_rs = i.urs; id_uses_rt = i.urt;
    id_rs = i.rs; id_rt = i.rt; id_dst = i.dst;
    id_regwrite = i.rw; id_memread = i.mr; branchtaken = i.bt;
  endtask

  task automatic drive(instr_t i);
    exp_t e;
    apply(i);
    e = expect_of(i);
    sbq.push_back(e);
    last_sid = e.sid;
    @(posedge clk);
    model_edge(i, e.sid, e.pc);
    #1;
  endtask

  task automatic issue(instr_t i);
    int n;
    n = 0;
    do begin
      drive(i);
      n++;
    end while (last_sid && n < 4);
  endtask

  function automatic instr_t mk(bit v, bit br, bit urs, bit urt, bit [4:0] rs, bit [4:0] rt,
                                bit [4:0] dst, bit rw, bit mr, bit bt);
    instr_t i;
    i = '{valid: v, br: br, urs: urs, urt: urt, rs: rs, rt: rt, dst: dst, rw: rw, mr: mr, bt: bt};
    return i;
  endfunction

  function automatic instr_t nop();   return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic instr_t alu(bit [4:0] d, bit [4:0] s, bit [4:0] t);
    return mk(1, 0, 1, 1, s, t, d, 1, 0, 0);
  endfunction
  function automatic instr_t ld(bit [4:0] d, bit [4:0] s);
    return mk(1, 0, 1, 0, s, 0, d, 1, 1, 0);
  endfunction
  function automatic instr_t beq(bit [4:0] s, bit [4:0] t, bit bt);
    return mk(1, 1, 1, 1, s, t, 0, 0, 0, bt);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e, a;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      a = '{fa: forwardAD, fb: forwardBD, sif: stall_if, sid: stall_id,
            pc: pc_src_branch, fl: flush_ifid, sc: stall_cnt, tc: taken_cnt};
      tests++;
      if (a !== e) begin
        failed++;
        $display("FAIL cycle@%0t: got fa=%0d fb=%0d sif=%0b sid=%0b pc=%0b fl=%0b sc=%0h tc=%0h expected fa=%0d fb=%0d sif=%0b sid=%0b pc=%0b fl=%0b sc=%0h tc=%0h",
                 $time, a.fa, a.fb, a.sif, a.sid, a.pc, a.fl, a.sc, a.tc,
                 e.fa, e.fb, e.sif, e.sid, e.pc, e.fl, e.sc, e.tc);
      end
    end
  end

  initial begin
    instr_t r, b;
    exp_t   e;
    tests = 0; failed = 0; stall_n = 0; taken_n = 0;
    rst = 1'b0;
    apply(beq(1, 2, 1));
    @(posedge clk); #1;
    drive(beq(1, 2, 1));
    drive(nop());
    rst = 1'b1;

    // T1..T4 directed sequences
    issue(beq(1, 2, 1));
    issue(alu(3, 1, 2)); issue(beq(3, 4, 0));
    issue(ld(5, 1));     issue(beq(6, 5, 1));
    issue(ld(5, 1));     issue(alu(8, 5, 2));
    issue(alu(7, 1, 1)); issue(alu(7, 2, 2)); issue(nop()); issue(beq(7, 0, 1));
    issue(alu(7, 1, 1)); issue(nop()); issue(nop()); issue(beq(0, 7, 0));
    issue(alu(0, 1, 1)); issue(beq(0, 0, 1)); issue(ld(0, 2)); issue(alu(9, 0, 0));

    // T5: taken held through a stall, then reset asserted mid-stall
    issue(ld(5, 1)); issue(beq(5, 5, 1));
    drive(ld(5, 1));
    b = beq(6, 5, 1);
    apply(b);
    e = expect_of(b);
    sbq.push_back(e);
    #6;
    rst = 1'b0;
    #1;
    chk("rst_stall_id", {31'd0, stall_id}, 32'd0);
    chk("rst_stall_if", {31'd0, stall_if}, 32'd0);
    chk("rst_pc_src", {31'd0, pc_src_branch}, 32'd0);
    chk("rst_flush", {31'd0, flush_ifid}, 32'd0);
    chk("rst_stall_cnt", {24'd0, stall_cnt}, 32'd0);
    chk("rst_taken_cnt", {24'd0, taken_cnt}, 32'd0);
    @(posedge clk);
    model_edge(b, 0, 0);
    #1;
    drive(b);
    rst = 1'b1;

    for (int k = 0; k < 1500; k++) begin
      r = nop();
      r.valid = ($urandom_range(0, 9) != 0);
      r.rs  = 5'($urandom_range(0, 7));
      r.rt  = 5'($urandom_range(0, 7));
      r.dst = 5'($urandom_range(0, 7));
      r.urs = $urandom_range(0, 3) != 0;
      r.urt = $urandom_range(0, 1) != 0;
      r.bt  = $urandom_range(0, 1) != 0;
      case ($urandom_range(0, 2))
        0: r.rw = $urandom_range(0, 4) != 0;
        1: begin r.rw = 1; r.mr = 1; end
        default: r.br = 1;
      endcase
      issue(r);
    end

    // T6: drive the stall counter into saturation
    for (int k = 0; k < 270; k++) begin
      issue(ld(5, 1));
      issue(alu(6, 5, 5));
    end
    drive(nop());
    chk("stall_cnt_sat", {24'd0, stall_cnt}, 32'd255);

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
